// File: rtl/cvxif_copro_pkg.sv
// Shared types for the CV-X-IF coprocessor: opcode, funct3 codes, buffer entry.
// CVXIF_COPRO_MUL_EN enables funct3 010 (MUL) in cvxif_copro_alu.
package cvxif_copro_pkg;

    localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

    // Entry fields are sized for the widest supported configuration.
    localparam int unsigned COPRO_XLEN_MAX = 64;
    localparam int unsigned COPRO_ID_MAX   = 8;

    typedef enum logic [2:0] {
        F3_ADD = 3'b000,
        F3_SUB = 3'b001,
        F3_MUL = 3'b010,
        F3_XOR = 3'b100,
        F3_NOP = 3'b111
    } copro_funct3_e;

    typedef struct packed {
        logic                      valid;
        logic                      committed;
        logic                      killed;
        logic                      we;
        logic [4:0]                rd;
        logic [COPRO_ID_MAX-1:0]   id;
        logic [COPRO_XLEN_MAX-1:0] data;
    } copro_entry_t;

endpackage

// File: rtl/cvxif_copro_alu.sv
// funct3 decode and arithmetic for the custom-0 opcode.
// MUL exists only when CVXIF_COPRO_MUL_EN is defined.
module cvxif_copro_alu
    import cvxif_copro_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            accept_o,
    output logic            writeback_o,
    output logic [XLEN-1:0] data_o
);

    copro_funct3_e f3;
    logic          unused_instr;

    assign f3           = copro_funct3_e'(instr_i[14:12]);
    assign unused_instr = ^{instr_i[31:15], instr_i[11:7]};

    // Decode opcode/funct3 and compute the result in the issue cycle.
    always_comb begin
        accept_o    = 1'b0;
        writeback_o = 1'b0;
        data_o      = '0;
        if (instr_i[6:0] == OPC_CUSTOM0) begin
            case (f3)
                F3_ADD: begin
                    accept_o    = 1'b1;
                    writeback_o = 1'b1;
                    data_o      = rs1_i + rs2_i;
                end
                F3_SUB: begin
                    accept_o    = 1'b1;
                    writeback_o = 1'b1;
                    data_o      = rs1_i - rs2_i;
                end
                F3_XOR: begin
                    accept_o    = 1'b1;
                    writeback_o = 1'b1;
                    data_o      = rs1_i ^ rs2_i;
                end
                F3_NOP: begin
                    accept_o    = 1'b1;
                end
`ifdef CVXIF_COPRO_MUL_EN
                F3_MUL: begin
                    accept_o    = 1'b1;
                    writeback_o = 1'b1;
                    data_o      = rs1_i * rs2_i;
                end
`endif
                default: begin
                    accept_o    = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/cvxif_pipelined_copro.sv
// CV-X-IF coprocessor: circular result buffer with commit/kill, in-order results.
// Optional MUL is controlled by CVXIF_COPRO_MUL_EN (see cvxif_copro_alu).
module cvxif_pipelined_copro
    import cvxif_copro_pkg::*;
#(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned ID_WIDTH = 3,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned LATENCY  = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [31:0]         issue_instr_i,
    input  logic [XLEN-1:0]     issue_rs1_i,
    input  logic [XLEN-1:0]     issue_rs2_i,
    input  logic [ID_WIDTH-1:0] issue_id_i,
    output logic                issue_accept_o,
    output logic                issue_writeback_o,
    input  logic                commit_valid_i,
    input  logic [ID_WIDTH-1:0] commit_id_i,
    input  logic                commit_kill_i,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [ID_WIDTH-1:0] result_id_o,
    output logic [XLEN-1:0]     result_data_o,
    output logic [4:0]          result_rd_o,
    output logic                result_we_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned AGE_W = 4;

    copro_entry_t     ent_q [DEPTH];
    copro_entry_t     ent_d [DEPTH];
    copro_entry_t     head;
    copro_entry_t     new_ent;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [AGE_W-1:0] age_q, age_d;
    logic             alu_accept;
    logic             alu_wb;
    logic [XLEN-1:0]  alu_data;
    logic             enq;
    logic             pop;
    logic             kill_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    cvxif_copro_alu #(
        .XLEN(XLEN)
    ) u_alu (
        .instr_i    (issue_instr_i),
        .rs1_i      (issue_rs1_i),
        .rs2_i      (issue_rs2_i),
        .accept_o   (alu_accept),
        .writeback_o(alu_wb),
        .data_o     (alu_data)
    );

    assign head              = ent_q[rptr_q];
    assign issue_ready_o     = count_q < CNT_W'(DEPTH);
    assign issue_accept_o    = alu_accept;
    assign issue_writeback_o = alu_wb;
    assign enq               = issue_valid_i && issue_ready_o && alu_accept;
    assign result_valid_o    = head.valid && head.committed && !head.killed
                               && (age_q == AGE_W'(LATENCY));
    assign kill_pop          = head.valid && head.committed && head.killed;
    assign pop               = (result_valid_o && result_ready_i) || kill_pop;
    assign result_id_o       = head.id[ID_WIDTH-1:0];
    assign result_data_o     = head.data[XLEN-1:0];
    assign result_rd_o       = head.rd;
    assign result_we_o       = head.we;

    // Build the entry for the current issue; a same-cycle commit lands on it.
    always_comb begin
        new_ent      = '0;
        new_ent.valid = 1'b1;
        new_ent.we   = alu_wb;
        new_ent.rd   = issue_instr_i[11:7];
        new_ent.id   = COPRO_ID_MAX'(issue_id_i);
        new_ent.data = COPRO_XLEN_MAX'(alu_data);
        if (commit_valid_i && (commit_id_i == issue_id_i)) begin
            new_ent.committed = 1'b1;
            new_ent.killed    = commit_kill_i;
        end
    end

    // Next-state: commit marking, pop/age, enqueue, occupancy.
    always_comb begin
        ent_d   = ent_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        age_d   = age_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (commit_valid_i && ent_q[i].valid
                && (ent_q[i].id == COPRO_ID_MAX'(commit_id_i))) begin
                ent_d[i].committed = 1'b1;
                if (commit_kill_i) begin
                    ent_d[i].killed = 1'b1;
                end
            end
        end
        if (pop) begin
            ent_d[rptr_q] = '0;
            rptr_d        = ptr_inc(rptr_q);
            age_d         = '0;
        end else if (head.valid && head.committed
                     && (age_q != AGE_W'(LATENCY))) begin
            age_d = age_q + 1'b1;
        end
        if (enq) begin
            ent_d[wptr_q] = new_ent;
            wptr_d        = ptr_inc(wptr_q);
        end
        case ({enq, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ent_q   <= '{default: '0};
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            age_q   <= '0;
        end else begin
            ent_q   <= ent_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            age_q   <= age_d;
        end
    end

endmodule

// File: tb/tb_cvxif_pipelined_copro.sv
// Directed bench for cvxif_pipelined_copro (default parameters).
// MUL expectations follow CVXIF_COPRO_MUL_EN.
module tb_cvxif_pipelined_copro;
    import cvxif_copro_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic [31:0] issue_instr_i;
    logic [63:0] issue_rs1_i;
    logic [63:0] issue_rs2_i;
    logic [2:0]  issue_id_i;
    logic        issue_accept_o;
    logic        issue_writeback_o;
    logic        commit_valid_i;
    logic [2:0]  commit_id_i;
    logic        commit_kill_i;
    logic        result_valid_o;
    logic        result_ready_i;
    logic [2:0]  result_id_o;
    logic [63:0] result_data_o;
    logic [4:0]  result_rd_o;
    logic        result_we_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cvxif_pipelined_copro dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .issue_valid_i    (issue_valid_i),
        .issue_ready_o    (issue_ready_o),
        .issue_instr_i    (issue_instr_i),
        .issue_rs1_i      (issue_rs1_i),
        .issue_rs2_i      (issue_rs2_i),
        .issue_id_i       (issue_id_i),
        .issue_accept_o   (issue_accept_o),
        .issue_writeback_o(issue_writeback_o),
        .commit_valid_i   (commit_valid_i),
        .commit_id_i      (commit_id_i),
        .commit_kill_i    (commit_kill_i),
        .result_valid_o   (result_valid_o),
        .result_ready_i   (result_ready_i),
        .result_id_o      (result_id_o),
        .result_data_o    (result_data_o),
        .result_rd_o      (result_rd_o),
        .result_we_o      (result_we_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op,
                                       input logic [2:0] f3,
                                       input logic [4:0] rd);
        return {7'b0, 5'd2, 5'd1, f3, rd, op};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] id, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [63:0] a,
                         input logic [63:0] b);
        issue_valid_i = 1'b1;
        issue_id_i    = id;
        issue_instr_i = mk(OPC_CUSTOM0, f3, rd);
        issue_rs1_i   = a;
        issue_rs2_i   = b;
        step();
        issue_valid_i = 1'b0;
    endtask

    task automatic commit(input logic [2:0] id, input logic kill);
        commit_valid_i = 1'b1;
        commit_id_i    = id;
        commit_kill_i  = kill;
        step();
        commit_valid_i = 1'b0;
        commit_kill_i  = 1'b0;
    endtask

    task automatic probe(input string tag, input logic [6:0] op,
                         input logic [2:0] f3, input logic acc,
                         input logic wb);
        issue_valid_i = 1'b0;
        issue_instr_i = mk(op, f3, 5'd1);
        #1;
        check_eq({tag, "_accept"}, 64'(issue_accept_o), 64'(acc));
        if (acc) begin
            check_eq({tag, "_wb"}, 64'(issue_writeback_o), 64'(wb));
        end
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!result_valid_o && n < 20) begin
            step();
            n++;
        end
        check_eq({tag, "_valid"}, 64'(result_valid_o), 64'd1);
    endtask

    task automatic wait_result(input string tag, input logic [2:0] id,
                               input logic [63:0] data, input logic we);
        wait_valid(tag);
        if (result_valid_o) begin
            check_eq({tag, "_id"}, 64'(result_id_o), 64'(id));
            check_eq({tag, "_data"}, result_data_o, data);
            check_eq({tag, "_we"}, 64'(result_we_o), 64'(we));
        end
        step();
    endtask

    task automatic no_result(input string tag, input int cycles);
        logic seen = 1'b0;
        repeat (cycles) begin
            if (result_valid_o) seen = 1'b1;
            step();
        end
        check_eq(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_i          = 1'b1;
        issue_valid_i  = 1'b0;
        issue_instr_i  = '0;
        issue_rs1_i    = '0;
        issue_rs2_i    = '0;
        issue_id_i     = '0;
        commit_valid_i = 1'b0;
        commit_id_i    = '0;
        commit_kill_i  = 1'b0;
        result_ready_i = 1'b1;
        repeat (2) step();
        rst_i = 1'b0;

        // Reset state
        check_eq("rst_ready", 64'(issue_ready_o), 64'd1);
        check_eq("rst_valid", 64'(result_valid_o), 64'd0);
        check_eq("rst_id", 64'(result_id_o), 64'd0);
        check_eq("rst_data", result_data_o, 64'd0);
        check_eq("rst_rd", 64'(result_rd_o), 64'd0);
        check_eq("rst_we", 64'(result_we_o), 64'd0);

        // ADD 5+7, latency counted from the commit edge
        issue_valid_i = 1'b1;
        issue_id_i    = 3'd1;
        issue_instr_i = mk(OPC_CUSTOM0, F3_ADD, 5'd3);
        issue_rs1_i   = 64'd5;
        issue_rs2_i   = 64'd7;
        #1;
        check_eq("add_accept", 64'(issue_accept_o), 64'd1);
        check_eq("add_wb", 64'(issue_writeback_o), 64'd1);
        step();
        issue_valid_i = 1'b0;
        commit(3'd1, 1'b0);
        check_eq("lat_c0", 64'(result_valid_o), 64'd0);
        step();
        check_eq("lat_c1", 64'(result_valid_o), 64'd0);
        step();
        check_eq("lat_c2", 64'(result_valid_o), 64'd1);
        check_eq("add_data", result_data_o, 64'd12);
        check_eq("add_id", 64'(result_id_o), 64'd1);
        check_eq("add_rd", 64'(result_rd_o), 64'd3);
        step();
        check_eq("add_popped", 64'(result_valid_o), 64'd0);

        // Full buffer, rejected 5th issue, drain with pointer wrap
        for (int i = 0; i < 4; i++) begin
            issue(3'(i), F3_ADD, 5'(i + 1), 64'(i), 64'd100);
        end
        check_eq("full_ready", 64'(issue_ready_o), 64'd0);
        issue(3'd4, F3_ADD, 5'd7, 64'd1, 64'd1);
        commit(3'd0, 1'b0);
        wait_valid("full_r0");
        check_eq("full_r0_id", 64'(result_id_o), 64'd0);
        check_eq("full_r0_data", result_data_o, 64'd100);
        check_eq("full_pop_ready", 64'(issue_ready_o), 64'd0);
        step();
        check_eq("after_pop_ready", 64'(issue_ready_o), 64'd1);
        commit(3'd1, 1'b0);
        wait_result("full_r1", 3'd1, 64'd101, 1'b1);
        commit(3'd2, 1'b0);
        wait_result("full_r2", 3'd2, 64'd102, 1'b1);
        commit(3'd3, 1'b0);
        wait_result("full_r3", 3'd3, 64'd103, 1'b1);
        commit(3'd4, 1'b0);
        no_result("no_5th_entry", 8);

        // Out-of-order commits, in-order results
        issue(3'd2, F3_XOR, 5'd4, 64'hFF, 64'h0F);
        issue(3'd3, F3_ADD, 5'd5, 64'd10, 64'd20);
        issue(3'd4, F3_SUB, 5'd6, 64'd50, 64'd8);
        commit(3'd4, 1'b0);
        commit(3'd3, 1'b0);
        commit(3'd2, 1'b0);
        wait_result("ord_2", 3'd2, 64'hF0, 1'b1);
        wait_result("ord_3", 3'd3, 64'd30, 1'b1);
        wait_result("ord_4", 3'd4, 64'd42, 1'b1);

        // Killed entry is dropped, next one follows
        issue(3'd5, F3_ADD, 5'd1, 64'd100, 64'd1);
        issue(3'd6, F3_ADD, 5'd2, 64'd1, 64'd2);
        commit(3'd5, 1'b1);
        commit(3'd6, 1'b0);
        wait_result("kill_next", 3'd6, 64'd3, 1'b1);

        // Back-pressure stability and SUB wrap-around
        result_ready_i = 1'b0;
        issue(3'd7, F3_SUB, 5'd9, 64'd0, 64'd1);
        commit(3'd7, 1'b0);
        wait_valid("stall");
        check_eq("sub_ones", result_data_o, 64'hFFFF_FFFF_FFFF_FFFF);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("stall_valid", 64'(result_valid_o), 64'd1);
            check_eq("stall_data", result_data_o, 64'hFFFF_FFFF_FFFF_FFFF);
            check_eq("stall_id", 64'(result_id_o), 64'd7);
            check_eq("stall_rd", 64'(result_rd_o), 64'd9);
        end
        result_ready_i = 1'b1;
        step();
        check_eq("stall_release", 64'(result_valid_o), 64'd0);

        // Decode corners and NOP
        probe("p_nop", OPC_CUSTOM0, F3_NOP, 1'b1, 1'b0);
        probe("p_opc", 7'b0110011, F3_ADD, 1'b0, 1'b0);
        probe("p_f3_011", OPC_CUSTOM0, 3'b011, 1'b0, 1'b0);
        probe("p_f3_101", OPC_CUSTOM0, 3'b101, 1'b0, 1'b0);
        issue(3'd1, F3_NOP, 5'd5, 64'd3, 64'd4);
        commit(3'd1, 1'b0);
        wait_result("nop", 3'd1, 64'd0, 1'b0);

        // MUL depends on build configuration
`ifdef CVXIF_COPRO_MUL_EN
        probe("p_mul", OPC_CUSTOM0, F3_MUL, 1'b1, 1'b1);
        issue(3'd0, F3_MUL, 5'd8, 64'd6, 64'd7);
        commit(3'd0, 1'b0);
        wait_result("mul", 3'd0, 64'd42, 1'b1);
`else
        probe("p_mul", OPC_CUSTOM0, F3_MUL, 1'b0, 1'b0);
        issue(3'd0, F3_MUL, 5'd8, 64'd6, 64'd7);
        commit(3'd0, 1'b0);
        no_result("mul_rejected", 8);
`endif

        // Reset with entries outstanding
        issue(3'd1, F3_ADD, 5'd1, 64'd1, 64'd1);
        issue(3'd2, F3_ADD, 5'd2, 64'd2, 64'd2);
        issue(3'd3, F3_ADD, 5'd3, 64'd3, 64'd3);
        commit(3'd1, 1'b0);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check_eq("mid_rst_ready", 64'(issue_ready_o), 64'd1);
        check_eq("mid_rst_valid", 64'(result_valid_o), 64'd0);
        commit(3'd2, 1'b0);
        commit(3'd3, 1'b0);
        no_result("mid_rst_none", 8);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cvxif_pipelined_copro.md
CVXIF_PIPELINED_COPRO -- requirements
Module: cvxif_pipelined_copro

Interface
REQ-001 SHALL have parameter XLEN, default 64, operand/result width.
REQ-002 SHALL have parameter ID_WIDTH, default 3, instruction-id width.
REQ-003 SHALL have parameter DEPTH, default 4, outstanding-entry count; legal range 2..16.
REQ-004 SHALL have parameter LATENCY, default 2, cycles from head-committed to result-valid; legal range 0..15.
REQ-005 SHALL have port clk_i  in  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_i  in  1  reset, synchronous and active-high.
REQ-007 SHALL have port issue_valid_i  in  1  issue request valid.
REQ-008 SHALL have port issue_ready_o  out  1  space available for one entry.
REQ-009 SHALL have port issue_instr_i  in  32  offloaded instruction word.
REQ-010 SHALL have port issue_rs1_i / issue_rs2_i  in  XLEN  source operands.
REQ-011 SHALL have port issue_id_i  in  ID_WIDTH  instruction id.
REQ-012 SHALL have port issue_accept_o  out  1  combinational decode result for the current issue request.
REQ-013 SHALL have port issue_writeback_o  out  1  accepted instruction writes rd.
REQ-014 SHALL have ports commit_valid_i  in  1, commit_id_i  in  ID_WIDTH, commit_kill_i  in  1  commit/kill notification.
REQ-015 SHALL have ports result_valid_o  out  1, result_ready_i  in  1, result_id_o  out  ID_WIDTH, result_data_o  out  XLEN, result_rd_o  out  5, result_we_o  out  1.

Function
REQ-016 SHALL accept an instruction only if opcode[6:0]==7'b0001011 (custom-0) and funct3 is supported; issue_accept_o SHALL be 0 otherwise.
REQ-017 SHALL support funct3 000 ADD (rs1+rs2), 001 SUB (rs1-rs2), 100 XOR, 111 NOP (no writeback, issue_writeback_o=0); arithmetic modulo 2^XLEN.
REQ-018 SHALL enqueue an entry when issue_valid_i && issue_ready_o && issue_accept_o; non-accepted handshakes SHALL create no entry.
REQ-019 SHALL compute the result at enqueue and store {id, rd, we, data, committed=0, killed=0} in a circular buffer of DEPTH entries.
REQ-020 issue_ready_o SHALL depend only on registered occupancy: 1 iff count<DEPTH; a same-cycle pop when full SHALL NOT raise it that cycle.
REQ-021 On commit_valid_i SHALL set committed (and killed if commit_kill_i) on the valid entry whose id matches; no match SHALL be ignored.
REQ-022 A commit whose id equals the id issued in the same cycle SHALL apply to the new entry.
REQ-023 A head age counter SHALL reset to 0 on every pop and increment each cycle the head is valid and committed, saturating at LATENCY.
REQ-024 result_valid_o SHALL be 1 iff head valid, committed, not killed, and age==LATENCY.
REQ-025 Pop SHALL occur on result_valid_o && result_ready_i, or in the cycle a committed killed entry is head (no result, one entry per cycle).
REQ-026 result_* SHALL stay stable while result_valid_o=1 and result_ready_i=0.
REQ-027 Results SHALL be returned strictly in issue order; read/write pointers wrap modulo DEPTH.
REQ-028 Simultaneous enqueue and pop SHALL leave count unchanged.

Reset
REQ-029 While rst_i=1 at a clock edge, SHALL clear all entries, pointers, count and age counter.
REQ-030 After reset: issue_ready_o=1, result_valid_o=0, result_id_o/data/rd/we=0.
REQ-031 Reset mid-operation SHALL discard all outstanding entries without producing results.

Configuration
REQ-032 With CVXIF_COPRO_MUL_EN defined, funct3 010 MUL (low XLEN bits of rs1*rs2) SHALL be accepted with writeback.
REQ-033 Without CVXIF_COPRO_MUL_EN, funct3 010 SHALL be rejected (issue_accept_o=0) and no multiplier SHALL be synthesised.

Structure
REQ-034 Package cvxif_copro_pkg SHALL hold the custom-0 opcode constant, funct3 enum and the buffer-entry struct typedef.
REQ-035 Sub-module cvxif_copro_alu SHALL implement the funct3 decode and arithmetic; buffer and control stay in the top.

Verification
REQ-036 Reset, then ADD rs1=5 rs2=7 id=1, commit id=1 next cycle -> result_data_o=12, result_id_o=1, result_valid_o exactly LATENCY=2 cycles after commit.
REQ-037 Issue 4 entries without commit -> issue_ready_o=0; 5th issue not accepted into buffer; commit+drain one -> issue_ready_o=1 next cycle.
REQ-038 Issue ids 2,3,4; commit 4 then 3 then 2 -> results emitted in order 2,3,4.
REQ-039 Issue id=5, commit with kill -> no result_valid_o; next entry id=6 result follows normally.
REQ-040 Hold result_ready_i=0 for 3 cycles with result pending -> result_* stable; SUB rs1=0 rs2=1 -> data all ones (XLEN bits).
REQ-041 funct3 010 -> issue_accept_o=1 and 6*7=42 with CVXIF_COPRO_MUL_EN; issue_accept_o=0 without; rst_i pulse with 3 entries pending -> no results, issue_ready_o=1.
